muldiv_unit: RTL and testbench

Iterative multiply/divide unit in the execute stage. It consumes the two register-file read operands (rd1 -> src_a, rd2 -> src_b) and computes MIPS-style MULT/MULTU/DIV/DIVU results into dedicated HI/LO registers. It also services MTHI/MTLO writes. It exposes busy so the pipeline stalls any HI/LO consumer, and done so downstream writeback knows HI/LO has updated.

---
 rtl/muldiv_unit.sv | 199 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS-style multiply/divide unit with HI/LO registers.
// Ports:
//   clk, rst_n    - rising-edge clock, asynchronous active-low reset
//   start, op     - request and opcode (MULT/MULTU/DIV/DIVU/MTHI/MTLO, 11x reserved)
//   src_a, src_b  - operands (rd1 / rd2); src_a is also the MTHI/MTLO data
//   cancel        - pipeline flush, aborts any in-flight operation
//   busy          - mul/div in progress (registered)
//   done          - one-cycle pulse after hi/lo are written by mul/div (registered)
//   hi, lo        - HI/LO registers
module muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITER  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(ITER);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // acc_hi/acc_lo: product high/low for mul, remainder/quotient for div
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  // mcand: multiplicand magnitude for mul, divisor magnitude for div
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;       // operand signs differ (signed ops only)
  logic             a_neg_q, a_neg_d;   // dividend negative (signed ops only)
  logic             b_zero_q, b_zero_d;
  logic             busy_d, done_d;
  logic [WIDTH-1:0] hi_d, lo_d;

  // Operand magnitudes for the capture edge
  logic             in_signed, in_a_neg, in_b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign in_signed = ~op[0];
  assign in_a_neg  = in_signed & src_a[WIDTH-1];
  assign in_b_neg  = in_signed & src_b[WIDTH-1];
  assign mag_a     = in_a_neg ? (-src_a) : src_a;
  assign mag_b     = in_b_neg ? (-src_b) : src_b;

  // One shift-add step: conditionally add mcand into the high half, shift right
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : (WIDTH+1)'(0));

  // One restoring step: shift next dividend bit into remainder, trial subtract
  logic [WIDTH:0] div_trial;
  assign div_trial = {acc_hi_q, acc_lo_q[WIDTH-1]} - {1'b0, mcand_q};

  // Sign-corrected results used in FIX
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign prod_raw = {acc_hi_q, acc_lo_q};
  assign prod_fix = neg_q ? (-prod_raw) : prod_raw;
  assign quo_fix  = neg_q ? (-acc_lo_q) : acc_lo_q;
  assign rem_fix  = a_neg_q ? (-acc_hi_q) : acc_hi_q;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      mcand_q  <= '0;
      a_q      <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      a_neg_q  <= 1'b0;
      b_zero_q <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      mcand_q  <= mcand_d;
      a_q      <= a_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      a_neg_q  <= a_neg_d;
      b_zero_q <= b_zero_d;
      busy     <= busy_d;
      done     <= done_d;
      hi       <= hi_d;
      lo       <= lo_d;
    end
  end

  // Next-state and datapath logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    mcand_d  = mcand_q;
    a_d      = a_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    a_neg_d  = a_neg_q;
    b_zero_d = b_zero_q;
    done_d   = 1'b0;
    hi_d     = hi;
    lo_d     = lo;

    unique case (state_q)
      S_IDLE: begin
        if (start && !cancel) begin
          unique case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              // Multiplication is commutative, so both ops share one capture layout
              state_d  = op[1] ? S_DIV : S_MUL;
              cnt_d    = '0;
              acc_hi_d = '0;
              acc_lo_d = mag_a;
              mcand_d  = mag_b;
              a_d      = src_a;
              is_div_d = op[1];
              neg_d    = in_a_neg ^ in_b_neg;
              a_neg_d  = in_a_neg;
              b_zero_d = (src_b == '0);
            end
            OP_MTHI: hi_d = src_a;
            OP_MTLO: lo_d = src_a;
            default: ;
          endcase
        end
      end
      S_MUL, S_DIV: begin
        if (cancel) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          if (state_q == S_MUL) begin
            acc_hi_d = mul_sum[WIDTH:1];
            acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
          end else if (div_trial[WIDTH]) begin
            acc_hi_d = {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]};
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
          end else begin
            acc_hi_d = div_trial[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
          end
          if (cnt_q == CNT_W'(ITER - 1)) begin
            state_d = S_FIX;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!cancel) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end else if (b_zero_q) begin
            hi_d = a_q;
            lo_d = '1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;

  localparam logic [2:0] MULT  = 3'b000;
  localparam logic [2:0] MULTU = 3'b001;
  localparam logic [2:0] DIV   = 3'b010;
  localparam logic [2:0] DIVU  = 3'b011;
  localparam logic [2:0] MTHI  = 3'b100;
  localparam logic [2:0] MTLO  = 3'b101;

  muldiv_unit #(.WIDTH(32), .ITER(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue a mul/div, optionally poke a DIVU start at edge-count 'inject', and check result + latency
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int inject);
    int cycles;
    start = 1'b1; op = o; src_a = a; src_b = b;
    tick();
    start = 1'b0; src_a = 32'hDEAD_BEEF; src_b = 32'h0000_0003;
    check({tag, " busy_after_start"}, 64'(busy), 64'd1);
    cycles = 0;
    while (busy && cycles < 100) begin
      if (inject > 0 && cycles == inject) begin
        start = 1'b1; op = DIVU; src_a = 32'd100; src_b = 32'd7;
      end
      tick();
      start = 1'b0;
      cycles++;
    end
    check({tag, " latency"}, 64'(cycles), 64'd33);
    check({tag, " done_pulse"}, 64'(done), 64'd1);
    check({tag, " hi"}, 64'(hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(lo), 64'(exp_lo));
    tick();
    check({tag, " done_clear"}, 64'(done), 64'd0);
  endtask

  initial begin
    int saw_done;
    logic [31:0] lo_keep;

    rst_n = 1'b0; start = 1'b0; op = 3'b000; src_a = '0; src_b = '0; cancel = 1'b0;
    #12;
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    tick();

    run_op("mult_neg1x2", MULT, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    run_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 0);
    run_op("mult_min", MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 0);
    run_op("div_m7_2", DIV, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    run_op("div_7_m2", DIV, 32'h7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, 0);
    run_op("divu_7_2", DIVU, 32'h7, 32'h2, 32'h1, 32'h3, 0);
    run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 0);
    run_op("divu_5_0", DIVU, 32'h5, 32'h0, 32'h5, 32'hFFFF_FFFF, 0);
    run_op("div_m5_0", DIV, 32'hFFFF_FFFB, 32'h0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 0);
    run_op("mult_inject", MULT, 32'h3, 32'h4, 32'h0, 32'hC, 5);

    // MTHI in IDLE
    start = 1'b1; op = MTHI; src_a = 32'h1234;
    tick();
    start = 1'b0;
    check("mthi_hi", 64'(hi), 64'h1234);
    check("mthi_busy", 64'(busy), 64'd0);
    check("mthi_done", 64'(done), 64'd0);
    tick();
    check("mthi_busy_after", 64'(busy), 64'd0);

    // MTLO blocked by cancel
    lo_keep = lo;
    start = 1'b1; op = MTLO; src_a = 32'h5555; cancel = 1'b1;
    tick();
    start = 1'b0; cancel = 1'b0;
    check("mtlo_cancel_lo", 64'(lo), 64'(lo_keep));

    // Reserved op is a no-op
    start = 1'b1; op = 3'b110; src_a = 32'h7777; src_b = 32'h1;
    tick();
    start = 1'b0;
    check("reserved_busy", 64'(busy), 64'd0);
    check("reserved_hi", 64'(hi), 64'h1234);
    check("reserved_lo", 64'(lo), 64'(lo_keep));

    // Cancel during iteration 10 of a MULT
    start = 1'b1; op = MTHI; src_a = 32'h1111;
    tick();
    lo_keep = lo;
    op = MULT; src_a = 32'd3; src_b = 32'd4;
    tick();
    start = 1'b0;
    repeat (10) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cancel_busy", 64'(busy), 64'd0);
    check("cancel_done", 64'(done), 64'd0);
    check("cancel_hi", 64'(hi), 64'h1111);
    check("cancel_lo", 64'(lo), 64'(lo_keep));
    saw_done = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) saw_done = 1;
    end
    check("cancel_no_done_later", 64'(saw_done), 64'd0);
    check("cancel_hi_later", 64'(hi), 64'h1111);

    // Asynchronous reset mid-DIV
    start = 1'b1; op = DIVU; src_a = 32'd100; src_b = 32'd7;
    tick();
    start = 1'b0;
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_hi", 64'(hi), 64'd0);
    check("arst_lo", 64'(lo), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    #3;
    rst_n = 1'b1;
    tick();
    tick();
    check("arst_stays_idle", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
